// File: rtl/irs3_serial_pkg.sv
// Shared IRS3 serial DAC frame layout and register map.
// Used by both the transmitter-side DAC init and the emulator receiver so
// both ends agree on the frame: 8-bit address then 12-bit data, MSB first.
package irs3_serial_pkg;

  localparam int unsigned IRS3_ADDR_W = 8;
  localparam int unsigned IRS3_DATA_W = 12;
  localparam int unsigned IRS3_WORD_W = IRS3_ADDR_W + IRS3_DATA_W;

  // IRS3 register addresses
  localparam logic [IRS3_ADDR_W-1:0] IRS3_REG_SBBIAS = 8'h00;
  localparam logic [IRS3_ADDR_W-1:0] IRS3_REG_ISEL   = 8'h01;
  localparam logic [IRS3_ADDR_W-1:0] IRS3_REG_VDLY   = 8'h02;
  localparam logic [IRS3_ADDR_W-1:0] IRS3_REG_VADJP  = 8'h03;
  localparam logic [IRS3_ADDR_W-1:0] IRS3_REG_VADJN  = 8'h04;

  // Frame word as it appears in the shift register after a full frame
  function automatic logic [IRS3_WORD_W-1:0] irs3_pack(
    input logic [IRS3_ADDR_W-1:0] addr,
    input logic [IRS3_DATA_W-1:0] data
  );
    return {addr, data};
  endfunction

endpackage

// File: rtl/irs3_serial_dac_rx_if.sv
// IRS3 serial DAC load bus: the five protocol pins plus the receiver's
// committed-write and status outputs.
//   master : drives SIN/SCLK/PCLK/REGCLR, observes SHOUT and write/status
//   slave  : the receiver (irs3_serial_dac_rx)
interface irs3_serial_dac_rx_if;
  import irs3_serial_pkg::*;

  logic                   irs_sin_i;
  logic                   irs_sclk_i;
  logic                   irs_pclk_i;
  logic                   irs_regclr_i;
  logic                   irs_shout_o;
  logic                   wr_o;
  logic [IRS3_ADDR_W-1:0] wr_addr_o;
  logic [IRS3_DATA_W-1:0] wr_data_o;
  logic [IRS3_DATA_W-1:0] sbbias_o;
  logic                   frame_err_o;
  logic                   busy_o;

  modport master (
    output irs_sin_i, irs_sclk_i, irs_pclk_i, irs_regclr_i,
    input  irs_shout_o, wr_o, wr_addr_o, wr_data_o, sbbias_o,
           frame_err_o, busy_o
  );

  modport slave (
    input  irs_sin_i, irs_sclk_i, irs_pclk_i, irs_regclr_i,
    output irs_shout_o, wr_o, wr_addr_o, wr_data_o, sbbias_o,
           frame_err_o, busy_o
  );
endinterface

// File: rtl/irs3_pin_sync.sv
// 2-flop synchronizer plus a third register for rising-edge detection.
//   clk_i, rst_n_i : system clock, synchronous active-low reset
//   pin_i          : asynchronous pin
//   sync_o         : synchronized level (2 stages)
//   rise_o         : one-cycle pulse on a synchronized rising edge
module irs3_pin_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic pin_i,
  output logic sync_o,
  output logic rise_o
);
  logic s1, s2, s3;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pin_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync_o = s2;
  assign rise_o = s2 & ~s3;
endmodule

// File: rtl/irs3_serial_dac_rx.sv
// IRS3 serial DAC load receiver (emulator side).
// Deserializes SIN on SCLK rising edges, commits {addr, data} on PCLK rising
// edges, drives SHOUT from shift register bit 19 and shadows SBBIAS.
//   clk_i, rst_n_i : system clock, synchronous active-low reset
//   bus (slave)    : SIN/SCLK/PCLK/REGCLR pins in; SHOUT, write strobe,
//                    address/data, sbbias shadow, sticky frame error, busy out
module irs3_serial_dac_rx
  import irs3_serial_pkg::*;
#(
  parameter logic [7:0]  SBBIAS_ADDR = IRS3_REG_SBBIAS,
  parameter int unsigned WORD_BITS   = IRS3_WORD_W
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  irs3_serial_dac_rx_if.slave  bus
);
  localparam logic [4:0] FULL_CNT = 5'(WORD_BITS);

  logic sin_sync, sclk_rise, pclk_rise, regclr_sync;
  logic unused_sin_rise, unused_sclk_sync, unused_pclk_sync, unused_regclr_rise;

  logic [IRS3_WORD_W-1:0] sr;
  logic [4:0]             bit_cnt;

  // SIN goes through the same depth as SCLK so the sampled bit lines up
  // with the detected SCLK edge.
  irs3_pin_sync u_sin (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .pin_i(bus.irs_sin_i),
    .sync_o(sin_sync), .rise_o(unused_sin_rise)
  );
  irs3_pin_sync u_sclk (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .pin_i(bus.irs_sclk_i),
    .sync_o(unused_sclk_sync), .rise_o(sclk_rise)
  );
  irs3_pin_sync u_pclk (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .pin_i(bus.irs_pclk_i),
    .sync_o(unused_pclk_sync), .rise_o(pclk_rise)
  );
  irs3_pin_sync u_regclr (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .pin_i(bus.irs_regclr_i),
    .sync_o(regclr_sync), .rise_o(unused_regclr_rise)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sr              <= '0;
      bit_cnt         <= '0;
      bus.irs_shout_o <= 1'b0;
      bus.wr_o        <= 1'b0;
      bus.wr_addr_o   <= '0;
      bus.wr_data_o   <= '0;
      bus.sbbias_o    <= '0;
      bus.frame_err_o <= 1'b0;
    end else begin
      bus.wr_o        <= 1'b0;
      bus.irs_shout_o <= sr[IRS3_WORD_W-1];
      if (regclr_sync) begin
        sr              <= '0;
        bit_cnt         <= '0;
        bus.sbbias_o    <= '0;
        bus.frame_err_o <= 1'b0;
      end else begin
        if (sclk_rise) begin
          sr <= {sr[IRS3_WORD_W-2:0], sin_sync};
          if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
        end
        // Commit reads the pre-shift sr; a coincident shift leaves one bit
        // already counted for the next frame and always flags an error.
        if (pclk_rise) begin
          bus.wr_o      <= 1'b1;
          bus.wr_addr_o <= sr[IRS3_WORD_W-1:IRS3_DATA_W];
          bus.wr_data_o <= sr[IRS3_DATA_W-1:0];
          if (sr[IRS3_WORD_W-1:IRS3_DATA_W] == SBBIAS_ADDR)
            bus.sbbias_o <= sr[IRS3_DATA_W-1:0];
          if (bit_cnt != FULL_CNT || sclk_rise)
            bus.frame_err_o <= 1'b1;
          bit_cnt <= sclk_rise ? 5'd1 : 5'd0;
        end
      end
    end
  end

  assign bus.busy_o = (bit_cnt != '0);
endmodule

// File: tb/tb_irs3_serial_dac_rx.sv
module tb_irs3_serial_dac_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  irs3_serial_dac_rx_if bus ();

  irs3_serial_dac_rx #(.SBBIAS_ADDR(8'h00), .WORD_BITS(20)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int wr_total = 0;

  // Reference model: frame rules at word level
  logic [19:0] m_sr;
  int          m_cnt;
  logic [11:0] m_sbb;
  logic        m_err;
  int          m_wr;

  always @(negedge clk) if (rst_n && bus.wr_o === 1'b1) wr_total++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_sr = '0; m_cnt = 0; m_sbb = '0; m_err = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.irs_sin_i = 0; bus.irs_sclk_i = 0; bus.irs_pclk_i = 0; bus.irs_regclr_i = 0;
    tick(2);
    rst_n = 1'b1;
    model_clear();
    m_wr = wr_total;
  endtask

  task automatic send_bit(input logic b);
    bus.irs_sin_i = b;
    tick(1);
    bus.irs_sclk_i = 1'b1;
    tick(4);
    m_sr = {m_sr[18:0], b};
    if (m_cnt < 31) m_cnt++;
    chk("shout", 32'(bus.irs_shout_o), 32'(m_sr[19]));
    bus.irs_sclk_i = 1'b0;
    tick(4);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  // PCLK pulse; optionally with a coincident SCLK rise carrying bit b
  task automatic commit(input bit with_sclk, input logic b);
    int seen;
    logic [7:0] a;
    logic [11:0] d;
    logic [11:0] sb;
    logic [19:0] exp_word;
    logic exp_err;
    seen = 0; a = '0; d = '0; sb = '0;
    exp_word = m_sr;
    exp_err = m_err | (m_cnt != 20) | with_sclk;
    if (with_sclk) begin
      bus.irs_sin_i = b;
      tick(1);
      bus.irs_sclk_i = 1'b1;
    end
    bus.irs_pclk_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (bus.wr_o === 1'b1) begin
        seen++; a = bus.wr_addr_o; d = bus.wr_data_o; sb = bus.sbbias_o;
      end
    end
    if (exp_word[19:12] == 8'h00) m_sbb = exp_word[11:0];
    m_err = exp_err;
    m_wr++;
    if (with_sclk) begin
      m_sr = {m_sr[18:0], b};
      m_cnt = 1;
    end else m_cnt = 0;
    chk("wr_pulses", 32'(seen), 32'd1);
    chk("wr_addr", 32'(a), 32'(exp_word[19:12]));
    chk("wr_data", 32'(d), 32'(exp_word[11:0]));
    chk("sbbias_at_wr", 32'(sb), 32'(m_sbb));
    chk("frame_err", 32'(bus.frame_err_o), 32'(m_err));
    chk("busy_after_commit", 32'(bus.busy_o), 32'(m_cnt != 0));
    bus.irs_pclk_i = 1'b0;
    bus.irs_sclk_i = 1'b0;
    tick(4);
  endtask

  task automatic chk_outputs_zero();
    chk("rst_shout", 32'(bus.irs_shout_o), 0);
    chk("rst_wr", 32'(bus.wr_o), 0);
    chk("rst_addr", 32'(bus.wr_addr_o), 0);
    chk("rst_data", 32'(bus.wr_data_o), 0);
    chk("rst_sbbias", 32'(bus.sbbias_o), 0);
    chk("rst_err", 32'(bus.frame_err_o), 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
  endtask

  initial begin
    logic [7:0]  ra;
    logic [11:0] rd;
    int          len;
    m_wr = 0;
    model_clear();

    // Reset then idle
    do_reset();
    chk_outputs_zero();
    tick(100);
    chk("idle_no_wr", 32'(wr_total), 32'(m_wr));
    chk_outputs_zero();

    // Single SBBIAS write
    send_bits({8'h00, 12'hA5C}, 20);
    chk("busy_mid", 32'(bus.busy_o), 1);
    commit(1'b0, 1'b0);
    chk("sbbias_A5C", 32'(bus.sbbias_o), 32'h A5C);

    // Non-SBBIAS write, then flush SHOUT with zeros
    send_bits({8'h13, 12'h001}, 20);
    commit(1'b0, 1'b0);
    chk("sbbias_kept", 32'(bus.sbbias_o), 32'hA5C);
    chk("shout_pre", 32'(bus.irs_shout_o), 32'(m_sr[19]));
    send_bits(32'h0, 20);
    chk("sr_flushed_shout", 32'(bus.irs_shout_o), 0);
    commit(1'b0, 1'b0);

    // Short frame: error sticks across a correct frame
    send_bits(32'h5_5555, 19);
    commit(1'b0, 1'b0);
    chk("short_err", 32'(bus.frame_err_o), 1);
    send_bits({8'h02, 12'h7E1}, 20);
    commit(1'b0, 1'b0);
    chk("err_sticky", 32'(bus.frame_err_o), 1);

    // Reset mid-frame discards partial word
    send_bits(32'h1F, 5);
    do_reset();
    chk_outputs_zero();
    chk("midreset_no_wr", 32'(wr_total), 32'(m_wr));

    // REGCLR mid-frame
    send_bits({8'h00, 12'h123}, 20);
    commit(1'b0, 1'b0);
    send_bits(32'h2AB, 10);
    bus.irs_regclr_i = 1'b1;
    tick(1);
    bus.irs_sclk_i = 1'b1; tick(1);
    bus.irs_sclk_i = 1'b0; tick(1);
    bus.irs_sclk_i = 1'b1; tick(1);
    bus.irs_sclk_i = 1'b0; tick(1);
    bus.irs_regclr_i = 1'b0;
    tick(4);
    model_clear();
    chk("regclr_sbbias", 32'(bus.sbbias_o), 0);
    chk("regclr_busy", 32'(bus.busy_o), 0);
    chk("regclr_err", 32'(bus.frame_err_o), 0);
    chk("regclr_shout", 32'(bus.irs_shout_o), 0);
    send_bits({8'h00, 12'h3FF}, 20);
    commit(1'b0, 1'b0);
    chk("regclr_then_3FF", 32'(bus.sbbias_o), 32'h3FF);
    chk("regclr_then_err", 32'(bus.frame_err_o), 0);

    // Simultaneous SCLK and PCLK
    send_bits({8'h00, 12'hC3A}, 20);
    commit(1'b1, 1'b1);
    chk("simul_busy", 32'(bus.busy_o), 1);
    chk("simul_err", 32'(bus.frame_err_o), 1);
    send_bits(32'h0, 19);
    commit(1'b0, 1'b0);

    // Randomized frames against the model
    do_reset();
    for (int n = 0; n < 12; n++) begin
      ra = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      rd = 12'($urandom);
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(17, 23)) : 20;
      if (len == 20) send_bits({12'h0, ra, rd}, 20);
      else send_bits($urandom, len);
      commit(1'b0, 1'b0);
      chk("rand_sbbias", 32'(bus.sbbias_o), 32'(m_sbb));
    end

    tick(10);
    chk("total_writes", 32'(wr_total), 32'(m_wr));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
